md_scheduler: RTL and testbench

MD_SCHEDULER -- requirements
Module: md_scheduler

---
 rtl/md_scheduler_pkg.sv | 27 ++
 rtl/md_datapath.sv | 49 ++++
 rtl/md_scheduler.sv | 93 +++++++++
 tb/tb_md_scheduler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/md_scheduler_pkg.sv
// Shared HI/LO unit definitions: op codes, FSM states and default latencies.
package md_scheduler_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    IDLE,
    RUN
  } md_state_e;

  function automatic logic is_div(input logic [2:0] o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic is_md(input logic [2:0] o);
    return (o == OP_MULT) || (o == OP_MULTU) || is_div(o);
  endfunction

endpackage

// File: rtl/md_datapath.sv
// Combinational 64-bit multiply/divide datapath for the HI/LO unit.
// we=0 means the result must not reach HI/LO (divide by zero, non-md op).
module md_datapath
  import md_scheduler_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res,
  output logic        we
);

  logic signed [63:0] sa;
  logic signed [63:0] sb;
  logic [31:0] ma;
  logic [31:0] mb;
  logic [31:0] dv;
  logic [31:0] q;
  logic [31:0] r;
  logic        sgn;

  always_comb begin
    res = '0;
    we  = 1'b1;
    sgn = (op == OP_MULT) || (op == OP_DIV);
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    // Signed divide works on magnitudes so MIN/-1 needs no special case.
    ma  = (sgn && a[31]) ? -a : a;
    mb  = (sgn && b[31]) ? -b : b;
    dv  = (mb == 32'd0) ? 32'd1 : mb;
    q   = ma / dv;
    r   = ma % dv;
    case (op)
      OP_MULT:  res = sa * sb;
      OP_MULTU: res = {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        res = {(a[31] ? -r : r), ((a[31] ^ b[31]) ? -q : q)};
        we  = (b != 32'd0);
      end
      OP_DIVU: begin
        res = {r, q};
        we  = (b != 32'd0);
      end
      default: we = 1'b0;
    endcase
  end

endmodule

// File: rtl/md_scheduler.sv
// HI/LO unit: issues multi-cycle MULT/DIV, tracks busy time, owns HI/LO.
// Result is captured at issue and committed when the busy period ends.
module md_scheduler
  import md_scheduler_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_in_d,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e   state;
  md_state_e   state_n;
  logic [3:0]  cnt;
  logic [3:0]  cnt_n;
  logic [63:0] res;
  logic        res_we;
  logic [63:0] dp_res;
  logic        dp_we;
  logic        load;
  logic        done;

  md_datapath u_dp (
    .op  (op),
    .a   (a),
    .b   (b),
    .res (dp_res),
    .we  (dp_we)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && is_md(op)) begin
          state_n = RUN;
          cnt_n   = is_div(op) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
          load    = 1'b1;
        end
      end
      RUN: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_n = IDLE;
          done    = 1'b1;
        end
      end
    endcase
  end

  assign busy  = (state == RUN);
  assign stall = md_in_d & (busy | (start & is_md(op)));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      res    <= '0;
      res_we <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (load) begin
        res    <= dp_res;
        res_we <= dp_we;
      end
      if (done && res_we) begin
        hi <= res[63:32];
        lo <= res[31:0];
      end else if (state == IDLE && start && op == OP_MTHI) begin
        hi <= a;
      end else if (state == IDLE && start && op == OP_MTLO) begin
        lo <= a;
      end
    end
  end

endmodule

// File: tb/tb_md_scheduler.sv
// Self-checking bench for md_scheduler against an arithmetic HI/LO model.
module tb_md_scheduler;
  import md_scheduler_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        md_in_d = 1'b0;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int failures = 0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  md_scheduler #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .md_in_d (md_in_d),
    .busy    (busy),
    .stall   (stall),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_md(input logic [2:0] o,
                                         input logic [31:0] x,
                                         input logic [31:0] y,
                                         input logic [31:0] h,
                                         input logic [31:0] l);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint unsigned ux = 64'(x);
    longint unsigned uy = 64'(y);
    logic [63:0] r = {h, l};
    case (o)
      OP_MULT:  r = 64'(sx * sy);
      OP_MULTU: r = ux * uy;
      OP_DIV:   if (y != 0) r = {32'(sx % sy), 32'(sx / sy)};
      OP_DIVU:  if (y != 0) r = {32'(ux % uy), 32'(ux / uy)};
      OP_MTHI:  r = {x, l};
      OP_MTLO:  r = {h, x};
      default:  r = {h, l};
    endcase
    return r;
  endfunction

  function automatic int ref_cycles(input logic [2:0] o);
    if (o == OP_MULT || o == OP_MULTU) return MC;
    if (o == OP_DIV || o == OP_DIVU) return DC;
    return 0;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    mhi = '0;
    mlo = '0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("FAIL reset_hilo got=%h_%h exp=0_0", hi, lo);
    end
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall got=%b exp=0", stall);
    end
  endtask

  task automatic test_one_op(input logic [2:0] o, input logic [31:0] x,
                             input logic [31:0] y, input logic d);
    int n;
    logic [63:0] e;
    logic exp_stall;
    n = ref_cycles(o);
    e = ref_md(o, x, y, mhi, mlo);
    @(negedge clk);
    assert (busy == 1'b0) else $error("start issued while busy");
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    md_in_d = d;
    #1;
    exp_stall = d && (n != 0);
    checks++;
    if (stall !== exp_stall) begin
      failures++;
      $display("FAIL start_stall op=%0d got=%b exp=%b", o, stall, exp_stall);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || stall !== d || hi !== mhi || lo !== mlo) begin
        failures++;
        $display("FAIL busy_cyc op=%0d i=%0d got=%b/%b/%h_%h exp=1/%b/%h_%h",
                 o, i, busy, stall, hi, lo, d, mhi, mlo);
      end
    end
    mhi = e[63:32];
    mlo = e[31:0];
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || stall !== 1'b0 || hi !== mhi || lo !== mlo) begin
      failures++;
      $display("FAIL result op=%0d a=%h b=%h got=%b/%b/%h_%h exp=0/0/%h_%h",
               o, x, y, busy, stall, hi, lo, mhi, mlo);
    end
    md_in_d = 1'b0;
  endtask

  task automatic test_mult();
    test_one_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL mult_const got=%h_%h exp=ffffffff_fffffffe", hi, lo);
    end
    test_one_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    checks++;
    if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL multu_const got=%h_%h exp=00000001_fffffffe", hi, lo);
    end
  endtask

  task automatic test_div();
    test_one_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      failures++;
      $display("FAIL div_const got=%h_%h exp=ffffffff_fffffffd", hi, lo);
    end
    test_one_op(OP_DIVU, 32'h1234_5678, 32'd0, 1'b0);
    test_one_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    checks++;
    if (hi !== 32'h0 || lo !== 32'h8000_0000) begin
      failures++;
      $display("FAIL div_min got=%h_%h exp=00000000_80000000", hi, lo);
    end
  endtask

  task automatic test_mt_stall();
    test_one_op(OP_MTHI, 32'h0000_1234, 32'd0, 1'b1);
    checks++;
    if (hi !== 32'h0000_1234) begin
      failures++;
      $display("FAIL mthi got=%h exp=00001234", hi);
    end
    test_one_op(OP_MTLO, 32'hCAFE_0001, 32'd0, 1'b0);
    test_one_op(3'd6, 32'hDEAD_BEEF, 32'd3, 1'b1);
    test_one_op(OP_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
  endtask

  task automatic test_reset_midop();
    test_one_op(OP_MTLO, 32'h5555_AAAA, 32'd0, 1'b0);
    @(negedge clk);
    start = 1'b1;
    op = OP_DIV;
    a = 32'd100;
    b = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    mhi = '0;
    mlo = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("FAIL midop_reset got=%b/%h_%h exp=0/0_0", busy, hi, lo);
    end
    repeat (DC + 2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("FAIL midop_late got=%b/%h_%h exp=0/0_0", busy, hi, lo);
    end
  endtask

  task automatic test_random();
    logic [2:0] o;
    logic [31:0] x;
    logic [31:0] y;
    for (int k = 0; k < 40; k++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 9));
        2: x = 32'h8000_0000;
        default: ;
      endcase
      test_one_op(o, x, y, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mt_stall();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
